// File: rtl/care_scheduler.sv
// Care-command scheduler for the pet stats datapath: turns button presses and a
// periodic decay tick into one valid/ready update stream with per-action cooldowns.

module care_action_lane #(
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic wrap_i,
    input  logic done_i,
    output logic pend_o,
    output logic cool_o,
    output logic rej_o
);
    logic       btn_q;
    logic       pend_q, pend_d;
    logic [3:0] cd_q, cd_d;
    logic       rise;

    assign rise = btn_i & ~btn_q;

    always_comb begin
        pend_d = pend_q;
        cd_d   = cd_q;
        if (wrap_i && (cd_q != 4'd0)) cd_d = cd_q - 4'd1;
        if (rise && (cd_q == 4'd0)) pend_d = 1'b1;
        // Completion beats both a same-edge press and a same-edge tick decrement.
        if (done_i) begin
            pend_d = 1'b0;
            cd_d   = 4'(COOLDOWN_TICKS);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q  <= 1'b0;
            pend_q <= 1'b0;
            cd_q   <= 4'd0;
        end else begin
            btn_q  <= btn_i;
            pend_q <= pend_d;
            cd_q   <= cd_d;
        end
    end

    assign pend_o = pend_q;
    assign cool_o = |cd_q;
    assign rej_o  = rise & (|cd_q);
endmodule

module care_scheduler #(
    parameter int TICK_CYCLES    = 1000,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] inputs,
    input  logic [7:0] random,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_stat,
    output logic       cmd_dec,
    output logic [3:0] cmd_amt,
    output logic [5:0] pending,
    output logic [5:0] cooling,
    output logic       reject
);
    localparam int NACT = 6;
    localparam int TW   = $clog2(TICK_CYCLES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            dpend_q, dpend_d;
    logic [2:0]      last_q, last_d;
    logic [2:0]      grant_q, grant_d;
    logic            is_decay_q, is_decay_d;
    logic [2:0]      stat_q, stat_d;
    logic            dec_q, dec_d;
    logic [3:0]      amt_q, amt_d;
    logic            wrap, hs;
    logic [2:0]      pick, decay_stat;
    logic [NACT-1:0] done, rej, pend, cool;
    logic            unused_bits;

    function automatic logic [2:0] rr_pick(input logic [NACT-1:0] req, input logic [2:0] last);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= NACT; k++) begin
            idx = (int'(last) + k) % NACT;
            if (!found && req[3'(idx)]) begin
                sel   = 3'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Action index doubles as stat index; only the magnitude differs per action.
    function automatic logic [3:0] act_amt(input logic [2:0] a);
        case (a)
            3'd0:    return 4'd4;
            3'd1:    return 4'd3;
            3'd2:    return 4'd5;
            3'd3:    return 4'd4;
            3'd4:    return 4'd8;
            default: return 4'd3;
        endcase
    endfunction

    assign wrap       = (tick_q == TW'(TICK_CYCLES - 1));
    assign tick_d     = wrap ? '0 : tick_q + TW'(1);
    assign hs         = (state_q == ISSUE) && cmd_ready;
    assign pick       = rr_pick(pend, last_q);
    assign decay_stat = (random[2:0] < 3'd6) ? random[2:0] : {1'b0, random[1:0]};

    for (genvar i = 0; i < NACT; i++) begin : g_lane
        assign done[i] = hs && !is_decay_q && (grant_q == 3'(i));
        care_action_lane #(.COOLDOWN_TICKS(COOLDOWN_TICKS)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (inputs[i]),
            .wrap_i (wrap),
            .done_i (done[i]),
            .pend_o (pend[i]),
            .cool_o (cool[i]),
            .rej_o  (rej[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        dpend_d    = dpend_q | wrap;
        last_d     = last_q;
        grant_d    = grant_q;
        is_decay_d = is_decay_q;
        stat_d     = stat_q;
        dec_d      = dec_q;
        amt_d      = amt_q;
        case (state_q)
            IDLE: begin
                if (dpend_q) begin
                    state_d    = ISSUE;
                    is_decay_d = 1'b1;
                    stat_d     = decay_stat;
                    dec_d      = 1'b0;
                    amt_d      = 4'd1;
                end else if (|pend) begin
                    state_d    = ISSUE;
                    is_decay_d = 1'b0;
                    grant_d    = pick;
                    stat_d     = pick;
                    dec_d      = 1'b1;
                    amt_d      = act_amt(pick);
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                    // A tick landing on the decay handshake starts the next decay.
                    if (is_decay_q) dpend_d = wrap;
                    else            last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            dpend_q    <= 1'b0;
            last_q     <= 3'd5;
            grant_q    <= 3'd0;
            is_decay_q <= 1'b0;
            stat_q     <= 3'd0;
            dec_q      <= 1'b0;
            amt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            dpend_q    <= dpend_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            is_decay_q <= is_decay_d;
            stat_q     <= stat_d;
            dec_q      <= dec_d;
            amt_q      <= amt_d;
        end
    end

    assign cmd_valid   = (state_q == ISSUE);
    assign cmd_stat    = stat_q;
    assign cmd_dec     = dec_q;
    assign cmd_amt     = amt_q;
    assign pending     = pend;
    assign cooling     = cool;
    assign reject      = |rej;
    assign unused_bits = ^{inputs[7:6], random[7:3]};
endmodule

// File: tb/tb_care_scheduler.sv
// Bench for care_scheduler: directed scenarios plus random traffic, all checked
// against an action/decay reference model kept here.

module tb_care_scheduler;
    localparam int TICKS = 8;
    localparam int COOL  = 4;

    logic       clk = 1'b0;
    logic       reset_r;
    logic [7:0] inputs_r, random_r;
    logic       cmd_ready_r;
    logic       cmd_valid, cmd_dec, reject;
    logic [2:0] cmd_stat;
    logic [3:0] cmd_amt;
    logic [5:0] pending, cooling;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] m_btn, m_pend;
    int         m_cd [6];
    int         m_tick, m_g, m_lg, m_stat, m_amt;
    logic       m_dpend, m_busy, m_isdec, m_dec;
    logic       exp_rej, act_rej;
    int         amt_tbl [6] = '{4, 3, 5, 4, 8, 3};

    care_scheduler #(.TICK_CYCLES(TICKS), .COOLDOWN_TICKS(COOL)) dut (
        .clk       (clk),
        .reset     (reset_r),
        .inputs    (inputs_r),
        .random    (random_r),
        .cmd_ready (cmd_ready_r),
        .cmd_valid (cmd_valid),
        .cmd_stat  (cmd_stat),
        .cmd_dec   (cmd_dec),
        .cmd_amt   (cmd_amt),
        .pending   (pending),
        .cooling   (cooling),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    task automatic mdl_reset();
        m_btn = '0; m_pend = '0; m_tick = 0; m_dpend = 1'b0; m_busy = 1'b0;
        m_isdec = 1'b0; m_g = 0; m_lg = 5; m_stat = 0; m_dec = 1'b0; m_amt = 0;
        for (int i = 0; i < 6; i++) m_cd[i] = 0;
    endtask

    function automatic logic mdl_reject();
        for (int i = 0; i < 6; i++)
            if (inputs_r[i] && !m_btn[i] && m_cd[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of the scheduler's rules, from the pre-edge state.
    task automatic mdl_edge();
        logic [5:0] np;
        logic       wrap, nd;
        int         ncd [6];
        int         r;
        wrap = (m_tick == TICKS - 1);
        np   = m_pend;
        nd   = m_dpend | wrap;
        for (int i = 0; i < 6; i++) begin
            ncd[i] = (wrap && m_cd[i] > 0) ? m_cd[i] - 1 : m_cd[i];
            if (inputs_r[i] && !m_btn[i] && m_cd[i] == 0) np[i] = 1'b1;
        end
        if (m_busy) begin
            if (cmd_ready_r) begin
                m_busy = 1'b0;
                if (m_isdec) nd = wrap;
                else begin
                    np[m_g] = 1'b0;
                    ncd[m_g] = COOL;
                    m_lg = m_g;
                end
            end
        end else if (m_dpend) begin
            r = int'(random_r) % 8;
            m_busy = 1'b1; m_isdec = 1'b1; m_dec = 1'b0; m_amt = 1;
            m_stat = (r < 6) ? r : r % 4;
        end else if (m_pend != 0) begin
            for (int k = 1; k <= 6; k++) begin
                if (m_pend[(m_lg + k) % 6]) begin
                    m_g = (m_lg + k) % 6;
                    break;
                end
            end
            m_busy = 1'b1; m_isdec = 1'b0; m_dec = 1'b1;
            m_stat = m_g; m_amt = amt_tbl[m_g];
        end
        m_pend  = np;
        m_cd    = ncd;
        m_dpend = nd;
        m_tick  = wrap ? 0 : m_tick + 1;
        m_btn   = inputs_r[5:0];
    endtask

    function automatic logic [20:0] mdl_vec();
        logic [5:0] cl;
        for (int i = 0; i < 6; i++) cl[i] = (m_cd[i] != 0);
        if (m_busy) return {1'b1, 3'(m_stat), m_dec, 4'(m_amt), m_pend, cl};
        return {9'd0, m_pend, cl};
    endfunction

    function automatic logic [20:0] dut_vec();
        if (cmd_valid) return {cmd_valid, cmd_stat, cmd_dec, cmd_amt, pending, cooling};
        return {9'd0, pending, cooling};
    endfunction

    // Drive one cycle's inputs between edges, sample reject before the edge,
    // advance the model on the edge, and leave time just past the edge.
    task automatic cyc(input logic [7:0] in, input logic [7:0] rnd, input logic rdy);
        inputs_r = in; random_r = rnd; cmd_ready_r = rdy;
        #2;
        exp_rej = mdl_reject();
        act_rej = reject;
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_r = 1'b1; inputs_r = '0; random_r = '0; cmd_ready_r = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_valid, cmd_stat, cmd_dec, cmd_amt, pending, cooling, reject} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h want 0",
                     {cmd_valid, cmd_stat, cmd_dec, cmd_amt, pending, cooling, reject});
        end
        @(negedge clk);
        reset_r = 1'b0;
    endtask

    task automatic test_feed();
        cyc(8'h01, 8'h00, 1'b1);
        n_cmp++;
        if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
            n_bad++;
            $display("FAIL feed_press t=%0t got %h/%b want %h/%b", $time, dut_vec(), act_rej, mdl_vec(), exp_rej);
        end
        cyc(8'h01, 8'h00, 1'b1);
        n_cmp++;
        if ({cmd_valid, cmd_stat, cmd_dec, cmd_amt} !== {1'b1, 3'd0, 1'b1, 4'd4}) begin
            n_bad++;
            $display("FAIL feed_cmd got %b want 1_000_1_0100", {cmd_valid, cmd_stat, cmd_dec, cmd_amt});
        end
        for (int c = 0; c < 45; c++) begin
            cyc((c == 2 || c >= 40) ? 8'h01 : 8'h00, 8'h00, 1'b1);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL feed_cool t=%0t got %h/%b want %h/%b", $time, dut_vec(), act_rej, mdl_vec(), exp_rej);
            end
            if (c == 2) begin
                n_cmp++;
                if ({act_rej, pending[0], cooling[0]} !== 3'b101) begin
                    n_bad++;
                    $display("FAIL feed_reject got rej/pend/cool %b want 101", {act_rej, pending[0], cooling[0]});
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 80; c++) begin
            if (!m_busy && m_pend == 0 && !m_dpend) break;
            cyc(8'h00, 8'($urandom), 1'b1);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL %s_drain t=%0t got %h want %h", tag, $time, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [23:0] code;
        int          n;
        drain("rr1");
        code = '0; n = 0;
        for (int c = 0; c < 40; c++) begin
            cyc((c == 0) ? 8'h2A : 8'h00, 8'($urandom), 1'b1);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL rr_three t=%0t got %h want %h", $time, dut_vec(), mdl_vec());
            end
            if (cmd_valid && cmd_dec) begin code = {code[20:0], cmd_stat}; n++; end
        end
        n_cmp++;
        if (n != 3 || code !== 24'o135) begin
            n_bad++;
            $display("FAIL rr_order1 got n=%0d %o want n=3 135", n, code);
        end
        for (int c = 0; c < 80; c++) begin
            if (cooling === 6'd0 && m_cd[0] == 0 && m_cd[1] == 0 && m_cd[3] == 0 && m_cd[5] == 0) break;
            cyc(8'h00, 8'($urandom), 1'b1);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL rr_wait t=%0t got %h want %h", $time, dut_vec(), mdl_vec());
            end
        end
        drain("rr2");
        code = '0; n = 0;
        for (int c = 0; c < 60; c++) begin
            cyc((c == 0) ? 8'h3F : 8'h00, 8'($urandom), 1'b1);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL rr_six t=%0t got %h want %h", $time, dut_vec(), mdl_vec());
            end
            if (cmd_valid && cmd_dec && n < 8) begin code = {code[20:0], cmd_stat}; n++; end
        end
        n_cmp++;
        if (n != 6 || code !== 24'o012345) begin
            n_bad++;
            $display("FAIL rr_order2 got n=%0d %o want n=6 012345", n, code);
        end
    endtask

    task automatic test_decay();
        logic [7:0] rnds  [4] = '{8'h07, 8'h02, 8'h0E, 8'h0D};
        logic [2:0] stats [4] = '{3'd3, 3'd2, 3'd2, 3'd5};
        logic       got;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int c = 0; c < 30 && !got; c++) begin
                cyc(8'h00, rnds[t], 1'b1);
                n_cmp++;
                if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                    n_bad++;
                    $display("FAIL decay_seq t=%0t got %h want %h", $time, dut_vec(), mdl_vec());
                end
                if (cmd_valid && !cmd_dec) begin
                    got = 1'b1;
                    n_cmp++;
                    if ({cmd_stat, cmd_amt} !== {stats[t], 4'd1}) begin
                        n_bad++;
                        $display("FAIL decay_cmd rnd=%h got stat %0d amt %0d want stat %0d amt 1",
                                 rnds[t], cmd_stat, cmd_amt, stats[t]);
                    end
                end
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL decay_timeout rnd=%h got no decay want one", rnds[t]);
            end
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 30 && !m_busy; c++) cyc(8'h00, 8'($urandom), 1'b0);
        n_cmp++;
        if (cmd_valid !== 1'b1 || !m_busy) begin
            n_bad++;
            $display("FAIL stall_enter got valid %b want 1", cmd_valid);
        end
        for (int c = 0; c < 30; c++) begin
            cyc((c == 3) ? 8'h10 : 8'h00, 8'($urandom), c >= 20);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL stall t=%0t c=%0d got %h want %h", $time, c, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] in;
        in = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) in[b] = ~in[b];
            cyc(in, 8'($urandom), $urandom_range(0, 3) != 0);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL random t=%0t got %h/%b want %h/%b", $time, dut_vec(), act_rej, mdl_vec(), exp_rej);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 30 && !m_busy; c++) cyc(8'h01, 8'($urandom), 1'b0);
        #2 reset_r = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_valid, cmd_stat, cmd_dec, cmd_amt, pending, cooling, reject} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_async got %h want 0",
                     {cmd_valid, cmd_stat, cmd_dec, cmd_amt, pending, cooling, reject});
        end
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_r = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc(8'h01, 8'h00, 1'b1);
            n_cmp++;
            if ({dut_vec(), act_rej} !== {mdl_vec(), exp_rej}) begin
                n_bad++;
                $display("FAIL reset_held t=%0t got %h want %h", $time, dut_vec(), mdl_vec());
            end
            if (c == 1) begin
                n_cmp++;
                if ({cmd_valid, cmd_stat, cmd_dec} !== 5'b1_000_1) begin
                    n_bad++;
                    $display("FAIL reset_held_cmd got %b want 10001", {cmd_valid, cmd_stat, cmd_dec});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_feed();
        test_round_robin();
        test_decay();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
